// File: rtl/lt_pkg.sv
// Shared types and constants for the link-training sequencer: FSM states,
// rate codes, failure codes and the lane-count to lane-mask helper.
package lt_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CFG,
      S_WAIT,
      S_REQ,
      S_EVAL_CR,
      S_EVAL_EQ,
      S_FALLBACK,
      S_PASS,
      S_FAIL
   } lt_state_e;

   localparam logic [7:0] BW_8G1  = 8'h1E;
   localparam logic [7:0] BW_5G4  = 8'h14;
   localparam logic [7:0] BW_2G7  = 8'h0A;
   localparam logic [7:0] BW_1G62 = 8'h06;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_CR      = 2'd1,
      FC_EQ      = 2'd2,
      FC_TIMEOUT = 2'd3
   } fail_code_e;

   localparam logic [1:0] TPS_OFF = 2'd0;
   localparam logic [1:0] TPS1    = 2'd1;

   // Lane code 0..3 selects 1/2/4/8 lanes; lanes are always packed from lane 0.
   function automatic logic [7:0] lane_mask(input logic [1:0] lc);
      case (lc)
         2'd0:    lane_mask = 8'h01;
         2'd1:    lane_mask = 8'h03;
         2'd2:    lane_mask = 8'h0F;
         default: lane_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lt_fallback_calc.sv
// Next rate/lane configuration after a failed attempt: step the rate down first,
// then drop one lane-count step and restart from the initial rate.
module lt_fallback_calc
   import lt_pkg::*;
(
   input  logic [7:0] bw,
   input  logic [1:0] lc,
   input  logic [7:0] link_bw,
   output logic [7:0] bw_nxt,
   output logic [1:0] lc_nxt,
   output logic       exhausted
);

   always_comb begin
      bw_nxt    = bw;
      lc_nxt    = lc;
      exhausted = 1'b0;
      if (bw > BW_1G62) begin
         if (bw > BW_5G4)      bw_nxt = BW_5G4;
         else if (bw > BW_2G7) bw_nxt = BW_2G7;
         else                  bw_nxt = BW_1G62;
      end else if (lc != 2'd0) begin
         lc_nxt = lc - 2'd1;
         bw_nxt = link_bw;
      end else begin
         exhausted = 1'b1;
      end
   end

endmodule

// File: rtl/lt_seq_ctrl.sv
// Link-training sequencer: clock recovery then channel equalisation across up to
// MAX_LANES lanes, with rate-then-lane-count fallback and a coded failure result.
module lt_seq_ctrl
   import lt_pkg::*;
#(
   parameter int MAX_LANES   = 4,
   parameter int CR_SAME_MAX = 5,
   parameter int CR_LOOP_MAX = 10,
   parameter int EQ_LOOP_MAX = 6,
   parameter int CR_WAIT_CYC = 10,
   parameter int EQ_WAIT_CYC = 40,
   parameter int STS_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [7:0]             link_bw,
   input  logic [1:0]             link_lc,
   input  logic [1:0]             eq_tps,
   input  logic [1:0]             max_vtg,
   output logic                   sts_req,
   input  logic                   sts_vld,
   input  logic [MAX_LANES-1:0]   sts_cr_done,
   input  logic [MAX_LANES-1:0]   sts_eq_done,
   input  logic [MAX_LANES-1:0]   sts_sym_lock,
   input  logic                   sts_align,
   input  logic [2*MAX_LANES-1:0] sts_adj_vtg,
   input  logic [2*MAX_LANES-1:0] sts_adj_pre,
   output logic [2*MAX_LANES-1:0] drv_vtg,
   output logic [2*MAX_LANES-1:0] drv_pre,
   output logic [7:0]             drv_bw,
   output logic [1:0]             drv_lc,
   output logic [1:0]             drv_tps,
   output logic                   drv_vld,
   output logic                   busy,
   output logic                   lt_pass,
   output logic                   lt_fail,
   output logic [1:0]             fail_code,
   output lt_state_e              dbg_state
);

   // Status handshake: sts_req is a one-cycle request; the sink answers with a
   // one-cycle sts_vld on any later cycle while REQ waits. sts_vld elsewhere is dropped.

   localparam logic [7:0]  CR_SAME_LIM = 8'(CR_SAME_MAX);
   localparam logic [7:0]  CR_LOOP_LIM = 8'(CR_LOOP_MAX);
   localparam logic [7:0]  EQ_LOOP_LIM = 8'(EQ_LOOP_MAX);
   localparam logic [15:0] CR_WAIT_LIM = 16'(CR_WAIT_CYC);
   localparam logic [15:0] EQ_WAIT_LIM = 16'(EQ_WAIT_CYC);
   localparam logic [15:0] TO_LAST     = 16'(STS_TIMEOUT - 1);
   localparam logic [1:0]  LC_MAX      = (MAX_LANES >= 8) ? 2'd3 :
                                         (MAX_LANES >= 4) ? 2'd2 :
                                         (MAX_LANES >= 2) ? 2'd1 : 2'd0;

   lt_state_e              state;
   logic                   phase_eq;
   logic [7:0]             cfg_bw;
   logic [1:0]             cfg_tps;
   logic [7:0]             cr_cnt, same_cnt, eq_cnt;
   logic [15:0]            wait_cnt, to_cnt;
   logic [MAX_LANES-1:0]   st_cr, st_eq, st_lock;
   logic                   st_align;
   logic [2*MAX_LANES-1:0] st_vtg, st_pre;

   logic [MAX_LANES-1:0]   act;
   logic [2*MAX_LANES-1:0] fld_mask, req_vtg, req_pre;
   logic                   all_cr, eq_ok, hit_max, same_vtg;
   logic [7:0]             same_nxt;
   logic [15:0]            wait_lim;
   logic [7:0]             fb_bw;
   logic [1:0]             fb_lc;
   logic                   fb_exh;

   assign act       = MAX_LANES'(lane_mask(drv_lc));
   assign same_nxt  = same_vtg ? same_cnt + 8'd1 : 8'd0;
   assign wait_lim  = phase_eq ? EQ_WAIT_LIM : CR_WAIT_LIM;
   assign dbg_state = state;

   // Inactive lanes never influence a decision and always drive zero.
   always_comb begin
      all_cr   = &(st_cr | ~act);
      eq_ok    = (&((st_eq & st_lock) | ~act)) & st_align;
      hit_max  = 1'b0;
      same_vtg = 1'b1;
      fld_mask = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (act[i]) begin
            fld_mask[2*i +: 2] = 2'b11;
            if (st_vtg[2*i +: 2] == max_vtg)            hit_max  = 1'b1;
            if (st_vtg[2*i +: 2] != drv_vtg[2*i +: 2])  same_vtg = 1'b0;
         end
      end
      req_vtg = st_vtg & fld_mask;
      req_pre = st_pre & fld_mask;
   end

   lt_fallback_calc u_fallback (
      .bw        (drv_bw),
      .lc        (drv_lc),
      .link_bw   (cfg_bw),
      .bw_nxt    (fb_bw),
      .lc_nxt    (fb_lc),
      .exhausted (fb_exh)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         phase_eq  <= 1'b0;
         cfg_bw    <= '0;
         cfg_tps   <= '0;
         cr_cnt    <= '0;
         same_cnt  <= '0;
         eq_cnt    <= '0;
         wait_cnt  <= '0;
         to_cnt    <= '0;
         st_cr     <= '0;
         st_eq     <= '0;
         st_lock   <= '0;
         st_align  <= 1'b0;
         st_vtg    <= '0;
         st_pre    <= '0;
         sts_req   <= 1'b0;
         drv_vtg   <= '0;
         drv_pre   <= '0;
         drv_bw    <= 8'h00;
         drv_lc    <= 2'd0;
         drv_tps   <= TPS_OFF;
         drv_vld   <= 1'b0;
         busy      <= 1'b0;
         lt_pass   <= 1'b0;
         lt_fail   <= 1'b0;
         fail_code <= FC_NONE;
      end else begin
         sts_req <= 1'b0;
         drv_vld <= 1'b0;
         lt_pass <= 1'b0;
         lt_fail <= 1'b0;
         if (abort && state != S_IDLE) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            drv_tps <= TPS_OFF;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  cfg_bw    <= link_bw;
                  cfg_tps   <= eq_tps;
                  drv_bw    <= link_bw;
                  drv_lc    <= (link_lc > LC_MAX) ? LC_MAX : link_lc;
                  fail_code <= FC_NONE;
                  busy      <= 1'b1;
                  state     <= S_CFG;
               end
               S_CFG: begin
                  drv_vtg  <= '0;
                  drv_pre  <= '0;
                  drv_tps  <= TPS1;
                  drv_vld  <= 1'b1;
                  cr_cnt   <= '0;
                  same_cnt <= '0;
                  eq_cnt   <= '0;
                  wait_cnt <= '0;
                  to_cnt   <= '0;
                  phase_eq <= 1'b0;
                  state    <= S_WAIT;
               end
               S_WAIT: if (wait_cnt == wait_lim) begin
                  wait_cnt <= '0;
                  to_cnt   <= '0;
                  sts_req  <= 1'b1;
                  state    <= S_REQ;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
               S_REQ: if (sts_vld) begin
                  st_cr    <= sts_cr_done;
                  st_eq    <= sts_eq_done;
                  st_lock  <= sts_sym_lock;
                  st_align <= sts_align;
                  st_vtg   <= sts_adj_vtg;
                  st_pre   <= sts_adj_pre;
                  state    <= phase_eq ? S_EVAL_EQ : S_EVAL_CR;
               end else if (to_cnt == TO_LAST) begin
                  fail_code <= FC_TIMEOUT;
                  state     <= S_FAIL;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
               S_EVAL_CR: if (all_cr) begin
                  drv_tps  <= cfg_tps;
                  drv_vld  <= 1'b1;
                  eq_cnt   <= '0;
                  phase_eq <= 1'b1;
                  state    <= S_WAIT;
               end else if (hit_max || (cr_cnt + 8'd1 == CR_LOOP_LIM)) begin
                  state <= S_FALLBACK;
               end else if (same_nxt == CR_SAME_LIM) begin
                  same_cnt <= same_nxt;
                  state    <= S_FALLBACK;
               end else begin
                  drv_vtg  <= req_vtg;
                  drv_pre  <= req_pre;
                  drv_vld  <= 1'b1;
                  cr_cnt   <= cr_cnt + 8'd1;
                  same_cnt <= same_nxt;
                  state    <= S_WAIT;
               end
               S_EVAL_EQ: if (!all_cr) begin
                  state <= S_FALLBACK;
               end else if (eq_ok) begin
                  state <= S_PASS;
               end else if (eq_cnt + 8'd1 == EQ_LOOP_LIM) begin
                  state <= S_FALLBACK;
               end else begin
                  drv_vtg <= req_vtg;
                  drv_pre <= req_pre;
                  drv_vld <= 1'b1;
                  eq_cnt  <= eq_cnt + 8'd1;
                  state   <= S_WAIT;
               end
               S_FALLBACK: if (fb_exh) begin
                  fail_code <= phase_eq ? FC_EQ : FC_CR;
                  state     <= S_FAIL;
               end else begin
                  drv_bw <= fb_bw;
                  drv_lc <= fb_lc;
                  state  <= S_CFG;
               end
               S_PASS: begin
                  lt_pass <= 1'b1;
                  drv_tps <= TPS_OFF;
                  drv_vld <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
               S_FAIL: begin
                  lt_fail <= 1'b1;
                  drv_tps <= TPS_OFF;
                  drv_vld <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lt_seq_ctrl.sv
// Bench for lt_seq_ctrl: acts as the sink, answers status reads with randomized
// patterns and checks every drv_vld word and the final result against a reference model.
module tb_lt_seq_ctrl;
   import lt_pkg::*;

   localparam int NL       = 4;
   localparam int CR_WAIT  = 10;
   localparam int EQ_WAIT  = 40;
   localparam int M_GOOD   = 0;
   localparam int M_STUCK  = 1;
   localparam int M_EQ_L3  = 2;
   localparam int M_ONE    = 3;
   localparam int M_RAND   = 4;
   localparam int M_TMO    = 5;

   logic          clk, rst, start, abort, sts_vld, sts_align;
   logic [7:0]    link_bw;
   logic [1:0]    link_lc, eq_tps, max_vtg;
   logic [NL-1:0] sts_cr_done, sts_eq_done, sts_sym_lock;
   logic [7:0]    sts_adj_vtg, sts_adj_pre;
   logic          sts_req, drv_vld, busy, lt_pass, lt_fail;
   logic [7:0]    drv_vtg, drv_pre, drv_bw;
   logic [1:0]    drv_lc, drv_tps, fail_code;
   lt_state_e     dbg_state;

   lt_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .link_bw(link_bw), .link_lc(link_lc), .eq_tps(eq_tps), .max_vtg(max_vtg),
      .sts_req(sts_req), .sts_vld(sts_vld), .sts_cr_done(sts_cr_done),
      .sts_eq_done(sts_eq_done), .sts_sym_lock(sts_sym_lock), .sts_align(sts_align),
      .sts_adj_vtg(sts_adj_vtg), .sts_adj_pre(sts_adj_pre),
      .drv_vtg(drv_vtg), .drv_pre(drv_pre), .drv_bw(drv_bw), .drv_lc(drv_lc),
      .drv_tps(drv_tps), .drv_vld(drv_vld), .busy(busy), .lt_pass(lt_pass),
      .lt_fail(lt_fail), .fail_code(fail_code), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [27:0] exp_q[$];
   int exp_end;   // 1 = pass, 2 = fail
   int exp_code;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_bw, m_link_bw;
   logic [1:0] m_lc, m_tps, m_eq_tps, m_max_vtg;
   logic [1:0] m_vtg[NL], m_pre[NL];
   bit         m_phase_eq;
   int         m_cr_cnt, m_same, m_eq_cnt;

   // status for the pending read
   logic [NL-1:0] s_cr, s_eq, s_lock;
   logic          s_align;
   logic [1:0]    s_vtg[NL], s_pre[NL];

   function automatic logic [27:0] pack_exp();
      logic [7:0] v, p;
      v = '0;
      p = '0;
      for (int i = 0; i < NL; i++) begin
         v[2*i +: 2] = m_vtg[i];
         p[2*i +: 2] = m_pre[i];
      end
      return {m_tps, m_bw, m_lc, v, p};
   endfunction

   task automatic model_cfg();
      m_tps = 2'd1;
      for (int i = 0; i < NL; i++) begin m_vtg[i] = 2'd0; m_pre[i] = 2'd0; end
      m_phase_eq = 1'b0;
      m_cr_cnt = 0; m_same = 0; m_eq_cnt = 0;
      exp_q.push_back(pack_exp());
   endtask

   task automatic model_fallback();
      if (m_bw > 8'h06) begin
         m_bw = (m_bw == 8'h1E) ? 8'h14 : (m_bw == 8'h14) ? 8'h0A : 8'h06;
         model_cfg();
      end else if (m_lc > 2'd0) begin
         m_lc = m_lc - 2'd1;
         m_bw = m_link_bw;
         model_cfg();
      end else begin
         m_tps = 2'd0;
         exp_end = 2;
         exp_code = m_phase_eq ? 2 : 1;
         exp_q.push_back(pack_exp());
      end
   endtask

   task automatic model_apply(input int n);
      for (int i = 0; i < NL; i++) begin
         m_vtg[i] = (i < n) ? s_vtg[i] : 2'd0;
         m_pre[i] = (i < n) ? s_pre[i] : 2'd0;
      end
   endtask

   task automatic model_read();
      int n;
      bit all_cr, eq_ok, hit, same;
      n = 1 << m_lc;
      all_cr = 1; eq_ok = s_align; hit = 0; same = 1;
      for (int i = 0; i < n; i++) begin
         if (!s_cr[i]) all_cr = 0;
         if (!(s_eq[i] && s_lock[i])) eq_ok = 0;
         if (s_vtg[i] == m_max_vtg) hit = 1;
         if (s_vtg[i] != m_vtg[i]) same = 0;
      end
      if (!m_phase_eq) begin
         if (all_cr) begin
            m_tps = m_eq_tps; m_phase_eq = 1; m_eq_cnt = 0;
            exp_q.push_back(pack_exp());
         end else if (hit || m_cr_cnt + 1 == 10) begin
            model_fallback();
         end else begin
            m_same = same ? m_same + 1 : 0;
            if (m_same == 5) model_fallback();
            else begin
               model_apply(n); m_cr_cnt++;
               exp_q.push_back(pack_exp());
            end
         end
      end else begin
         if (!all_cr) model_fallback();
         else if (eq_ok) begin
            m_tps = 2'd0; exp_end = 1; exp_code = 0;
            exp_q.push_back(pack_exp());
         end else if (m_eq_cnt + 1 == 6) model_fallback();
         else begin
            model_apply(n); m_eq_cnt++;
            exp_q.push_back(pack_exp());
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic gen_status(input int mode, input int rd);
      for (int i = 0; i < NL; i++) begin
         s_vtg[i] = 2'($urandom_range(0, 3));
         s_pre[i] = 2'($urandom_range(0, 3));
      end
      case (mode)
         M_GOOD: begin s_cr = '1; s_eq = '1; s_lock = '1; s_align = 1'b1; end
         M_STUCK: begin
            s_cr = '0; s_eq = 4'($urandom); s_lock = 4'($urandom); s_align = 1'($urandom);
            for (int i = 0; i < NL; i++) s_vtg[i] = 2'd1;
         end
         M_EQ_L3: begin s_cr = '1; s_eq = '1; s_lock = 4'b0111; s_align = 1'b1; end
         M_ONE: begin
            if (rd == 0) begin
               s_cr = '0; s_eq = '0; s_lock = '0; s_align = 1'b0;
               s_vtg[0] = 2'd1; s_pre[0] = 2'd2;
               for (int i = 1; i < NL; i++) begin s_vtg[i] = 2'd3; s_pre[i] = 2'd3; end
            end else begin
               s_cr = 4'b0001; s_eq = 4'b0001; s_lock = 4'b0001; s_align = 1'b1;
            end
         end
         default: begin
            for (int i = 0; i < NL; i++) begin
               s_cr[i]   = ($urandom_range(0, 9) < 8);
               s_eq[i]   = ($urandom_range(0, 9) < 9);
               s_lock[i] = ($urandom_range(0, 9) < 9);
               s_vtg[i]  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            s_align = ($urandom_range(0, 9) < 9);
         end
      endcase
   endtask

   task automatic drive_status();
      for (int i = 0; i < NL; i++) begin
         sts_adj_vtg[2*i +: 2] = s_vtg[i];
         sts_adj_pre[2*i +: 2] = s_pre[i];
      end
      sts_cr_done = s_cr; sts_eq_done = s_eq; sts_sym_lock = s_lock; sts_align = s_align;
      sts_vld = 1'b1;
   endtask

   task automatic drive_start(input logic [7:0] bw, input logic [1:0] lc,
                              input logic [1:0] tps, input logic [1:0] mv);
      @(negedge clk);
      sts_vld = 1'b0;
      link_bw = bw; link_lc = lc; eq_tps = tps; max_vtg = mv;
      start = 1'b1;
      m_link_bw = bw; m_bw = bw; m_lc = lc; m_eq_tps = tps; m_max_vtg = mv;
      exp_end = 0; exp_code = 0;
      exp_q.delete();
      model_cfg();
   endtask

   task automatic run_train(input logic [7:0] bw, input logic [1:0] lc, input logic [1:0] tps,
                            input logic [1:0] mv, input int mode);
      int cyc, last_vld, req_cyc, pend, rd;
      bit done, awaiting;
      drive_start(bw, lc, tps, mv);
      cyc = 0; last_vld = 0; req_cyc = 0; pend = 0; rd = 0; done = 0; awaiting = 0;
      while (!done && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         sts_vld = 1'b0;
         if (cyc == 1) check("busy_rise", busy, 1);
         if (cyc == 7) begin start = 1'b1; link_bw = 8'h06; link_lc = 2'd0; end
         if (drv_vld) begin
            if (exp_q.size() == 0) check("drv_vld_extra", 1, 0);
            else check("drv_word", {drv_tps, drv_bw, drv_lc, drv_vtg, drv_pre}, exp_q.pop_front());
            if (last_vld == 0) check("start_to_drv_vld", cyc, 2);
            last_vld = cyc;
         end
         if (sts_req) begin
            check("drv_vld_to_sts_req", cyc - last_vld, (m_phase_eq ? EQ_WAIT : CR_WAIT) + 1);
            req_cyc = cyc;
            awaiting = 1;
            if (mode == M_TMO) begin
               m_tps = 2'd0; exp_end = 2; exp_code = 3;
               exp_q.push_back(pack_exp());
            end else begin
               gen_status(mode, rd);
               rd++;
               model_read();
               pend = $urandom_range(0, 4);
            end
         end
         if (lt_pass || lt_fail) begin
            check("end_kind", (lt_fail ? 2 : 0) + (lt_pass ? 1 : 0), exp_end);
            check("fail_code", fail_code, exp_code);
            check("busy_end", busy, 0);
            check("exp_q_drained", exp_q.size(), 0);
            if (mode == M_TMO) check("timeout_len", (cyc - req_cyc >= 255 && cyc - req_cyc <= 257), 1);
            done = 1;
         end
         if (awaiting && mode != M_TMO) begin
            if (pend == 0) begin drive_status(); awaiting = 0; end
            else pend--;
         end else if (!awaiting && $urandom_range(0, 15) == 0) begin
            sts_cr_done = 4'($urandom); sts_adj_vtg = 8'($urandom);
            sts_vld = 1'b1;
         end
      end
      if (!done) check("run_completed", 0, 1);
      start = 1'b0;
      sts_vld = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   int pulses;
   logic [7:0] bw_tab[4];

   initial begin
      bw_tab[0] = 8'h1E; bw_tab[1] = 8'h14; bw_tab[2] = 8'h0A; bw_tab[3] = 8'h06;
      rst = 1'b1; start = 1'b0; abort = 1'b0; sts_vld = 1'b0;
      link_bw = '0; link_lc = '0; eq_tps = 2'd2; max_vtg = 2'd3;
      sts_cr_done = '0; sts_eq_done = '0; sts_sym_lock = '0; sts_align = 1'b0;
      sts_adj_vtg = '0; sts_adj_pre = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_drv", {drv_tps, drv_bw, drv_lc, drv_vtg, drv_pre}, 0);
      check("rst_pulses", {sts_req, drv_vld, lt_pass, lt_fail}, 0);
      check("rst_fail_code", fail_code, 0);

      run_train(8'h1E, 2'd2, 2'd2, 2'd3, M_GOOD);
      check("pass_bw", drv_bw, 8'h1E);
      check("pass_lc", drv_lc, 2);
      run_train(8'h1E, 2'd2, 2'd3, 2'd3, M_STUCK);
      run_train(8'h1E, 2'd2, 2'd3, 2'd3, M_EQ_L3);
      run_train(8'h14, 2'd0, 2'd2, 2'd3, M_ONE);
      run_train(8'h0A, 2'd1, 2'd2, 2'd3, M_TMO);

      // abort while idle leaves the held result untouched
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("idle_abort_code", fail_code, 3);
      check("idle_abort_busy", busy, 0);

      // abort during WAIT
      drive_start(8'h1E, 2'd2, 2'd2, 2'd3);
      pulses = 0;
      for (int i = 0; i < 10 && pulses == 0; i++) begin
         @(negedge clk); start = 1'b0;
         if (drv_vld) pulses = 1;
      end
      check("abort_seen_drv_vld", pulses, 1);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_tps", drv_tps, 0);
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (drv_vld || sts_req || lt_pass || lt_fail) pulses++;
      end
      check("abort_quiet", pulses, 0);

      for (int r = 0; r < 8; r++)
         run_train(bw_tab[$urandom_range(0, 3)], 2'($urandom_range(0, 2)),
                   2'($urandom_range(2, 3)), 2'($urandom_range(2, 3)), M_RAND);

      // reset in the middle of training
      drive_start(8'h14, 2'd1, 2'd2, 2'd3);
      repeat (20) begin @(negedge clk); start = 1'b0; end
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_drv", {drv_tps, drv_bw, drv_lc, drv_vtg, drv_pre}, 0);
      check("midrst_pulses", {sts_req, drv_vld, lt_pass, lt_fail}, 0);
      check("midrst_fail_code", fail_code, 0);
      run_train(8'h0A, 2'd2, 2'd2, 2'd3, M_GOOD);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
